rv_writeback: RTL and testbench
===============================

# rv_writeback

Writeback stage of the uRV pipeline, directly downstream of the execute stage. Takes execute's registered result bundle (rd, value, write enable, load/store flags, funct3, data-memory address), finishes outstanding data-memory loads and stores, and aligns and sign-extends load data. It drives the single register-file write port and requests a pipeline stall while a memory access is still pending.

## Interface
- STORE_WAIT, default 1: 1 = stores also stall until `dm_store_done_i`; 0 = stores retire immediately.

- clk_i  in  1  pipeline clock
- rst_n_i  in  1  reset, asynchronous, active-low
- x_fun_i  in  3  funct3 of the instruction in writeback
- x_load_i  in  1  instruction is a load (single-cycle qualifier from execute)
- x_store_i  in  1  instruction is a store (single-cycle qualifier)
- x_rd_i  in  5  destination register
- x_rd_value_i  in  32  ALU result for non-load writes
- x_rd_write_i  in  1  non-load register write request
- x_dm_addr_i  in  32  data-memory byte address of the load/store
- dm_data_l_i  in  32  load data word from data memory
- dm_load_done_i  in  1  load data valid this cycle
- dm_store_done_i  in  1  store accepted this cycle
- rf_rd_o  out  5  register-file write address
- rf_rd_value_o  out  32  register-file write data
- rf_rd_write_o  out  1  register-file write strobe
- w_stall_req_o  out  1  stall request to execute and earlier stages
- w_misaligned_o  out  1  misaligned-load pulse (configuration-dependent)

## Operation
- States: IDLE, WAIT_LOAD, WAIT_STORE.
- IDLE, `x_load_i=1`:
  - With `dm_load_done_i=1`: the aligned value is written this edge. State stays IDLE.
  - Otherwise: latch rd, funct3, and addr[1:0] into the hold registers, then go to WAIT_LOAD.
- IDLE, `x_store_i=1`, STORE_WAIT=1, `dm_store_done_i=0`: go to WAIT_STORE. Stores never write the register file.
- IDLE, `x_rd_write_i=1`: write `x_rd_value_i` to `x_rd_i`.
- WAIT_LOAD: all `x_*` inputs are ignored.
  - On `dm_load_done_i`: write the aligned data to the held rd, then go to IDLE.
- WAIT_STORE: on `dm_store_done_i`, go to IDLE.
- Load alignment uses funct3 and addr[1:0]:
  - 000 LB: byte addr[1:0], sign-extended.
  - 100 LBU: same byte, zero-extended.
  - 001 LH: halfword addr[1], sign-extended.
  - 101 LHU: same halfword, zero-extended.
  - 010 LW: full word.
  - Any other funct3: write suppressed.
- Writes with rd = 0 are always suppressed: strobe stays 0, address and data are don't-care.
- `w_stall_req_o` (combinational) is 1 when any of:
  - IDLE & `x_load_i` & !`dm_load_done_i`
  - IDLE & `x_store_i` & STORE_WAIT & !`dm_store_done_i`
  - WAIT_LOAD & !`dm_load_done_i`
  - WAIT_STORE & !`dm_store_done_i`
- Simultaneous `x_load_i` and `x_store_i`: illegal. The load takes priority.
- `x_load_i` plus `x_rd_write_i` in the same cycle: the load path wins.

## Timing
- `rf_*` and `w_misaligned_o` are registered. They update on the clock edge at which the load, or the non-load write, completes.
  - So the value appears one cycle after `dm_load_done_i`, or one cycle after `x_rd_write_i` is presented.
- `rf_rd_write_o` and `w_misaligned_o` are single-cycle pulses.
- Zero-wait load: `dm_load_done_i` in the same cycle as `x_load_i` gives no stall cycle.
- Reset (asynchronous, any state): state goes to IDLE; `rf_rd_o=0`, `rf_rd_value_o=0`, `rf_rd_write_o=0`, `w_misaligned_o=0`, hold registers 0; `w_stall_req_o` follows its combinational equation from IDLE.
- Reset during WAIT_LOAD: the pending load is dropped and no write occurs after reset release.
- A `dm_load_done_i` or `dm_store_done_i` arriving while in IDLE with no access pending is ignored.

## Configuration
- Macro: `URV_WB_MISALIGN_CHECK_EN`.
- Defined:
  - A load is misaligned when it is LH/LHU with addr[0]=1, or LW with addr[1:0]≠00.
  - A misaligned load still waits for `dm_load_done_i`.
  - At completion: register write suppressed and `w_misaligned_o` pulses for one cycle.
- Undefined:
  - `w_misaligned_o` is tied 0.
  - Misaligned halfword/word loads use addr[1] / addr[1:0] truncated: halfword at addr[1]*2, word at 0.

## Structure
- `rv_defs.v` holds:
  - the `LDST_B/H/L/BU/HU` funct3 constants;
  - the writeback state encodings `WB_IDLE/WB_WAIT_LOAD/WB_WAIT_STORE`.
- One combinational sub-module, `rv_load_align`:
  - inputs: data word, funct3, addr[1:0];
  - outputs: aligned 32-bit value, valid-funct flag, misaligned flag.
- FSM, hold registers and RF output registers live in `rv_writeback`.

## Test plan
- ALU write: `x_rd_write_i=1`, rd=5, value=0xDEADBEEF → next cycle `rf_rd_write_o=1`, rd=5, data 0xDEADBEEF. rd=0 with the same stimulus → no strobe.
- Zero-wait LB: addr=…3, data=0x80FF_1234, done same cycle → rd gets 0xFFFF_FF80, `w_stall_req_o` never 1. Same access as LBU → 0x0000_0080.
- Waited LH:
  - Stimulus: addr=…2, done asserted 3 cycles later with data 0x9ABC_0000.
  - Stall held for exactly 3 cycles, `x_*` toggled meanwhile is ignored.
  - Write of 0xFFFF_9ABC one cycle after done.
- Store with STORE_WAIT=1: done after 2 cycles → stall for 2 cycles, no RF write. With STORE_WAIT=0 → no stall.
- Misaligned LW at addr 0x…1:
  - With the macro: no write, `w_misaligned_o` pulses once.
  - Without the macro: rd gets the full word.
- Reset asserted mid-WAIT_LOAD → all outputs 0 immediately. Done pulsed after release → no write.

Source files
------------

// File: rtl/rv_writeback_pkg.sv
// Shared definitions for the uRV writeback stage: load/store funct3 encodings
// and the writeback FSM state type.
package rv_writeback_pkg;

  // funct3 encodings of the load/store instructions
  localparam logic [2:0] LDST_B  = 3'b000;
  localparam logic [2:0] LDST_H  = 3'b001;
  localparam logic [2:0] LDST_L  = 3'b010;
  localparam logic [2:0] LDST_BU = 3'b100;
  localparam logic [2:0] LDST_HU = 3'b101;

  // Writeback FSM states
  typedef enum logic [1:0] {
    WB_IDLE       = 2'b00,
    WB_WAIT_LOAD  = 2'b01,
    WB_WAIT_STORE = 2'b10
  } wb_state_e;

endpackage

// File: rtl/rv_load_align.sv
// Load data alignment: selects the addressed byte/halfword of a memory word and
// sign- or zero-extends it according to funct3. Also flags unsupported funct3
// values and misaligned halfword/word accesses.
module rv_load_align
  import rv_writeback_pkg::*;
(
  input  logic [31:0] data_i,
  input  logic [2:0]  fun_i,
  input  logic [1:0]  addr_i,
  output logic [31:0] value_o,
  output logic        valid_o,
  output logic        misaligned_o
);

  logic [7:0]  byte_sel;
  logic [15:0] half_sel;

  // Lane selection; a misaligned halfword/word simply truncates the low address bits
  always_comb begin
    unique case (addr_i)
      2'b00:   byte_sel = data_i[7:0];
      2'b01:   byte_sel = data_i[15:8];
      2'b10:   byte_sel = data_i[23:16];
      default: byte_sel = data_i[31:24];
    endcase
    half_sel = addr_i[1] ? data_i[31:16] : data_i[15:0];
  end

  // Extension and funct3 decode
  always_comb begin
    value_o      = '0;
    valid_o      = 1'b0;
    misaligned_o = 1'b0;
    case (fun_i)
      LDST_B: begin
        value_o = {{24{byte_sel[7]}}, byte_sel};
        valid_o = 1'b1;
      end
      LDST_BU: begin
        value_o = {24'b0, byte_sel};
        valid_o = 1'b1;
      end
      LDST_H: begin
        value_o      = {{16{half_sel[15]}}, half_sel};
        valid_o      = 1'b1;
        misaligned_o = addr_i[0];
      end
      LDST_HU: begin
        value_o      = {16'b0, half_sel};
        valid_o      = 1'b1;
        misaligned_o = addr_i[0];
      end
      LDST_L: begin
        value_o      = data_i;
        valid_o      = 1'b1;
        misaligned_o = |addr_i;
      end
      default: begin
        value_o = '0;
        valid_o = 1'b0;
      end
    endcase
  end

endmodule

// File: rtl/rv_writeback.sv
// uRV writeback stage. Completes outstanding data-memory loads/stores, aligns
// load data and drives the single register-file write port. Stalls upstream
// while an access is pending.
// Optional feature: define URV_WB_MISALIGN_CHECK_EN to suppress writes of
// misaligned halfword/word loads and pulse w_misaligned_o instead.
module rv_writeback
  import rv_writeback_pkg::*;
#(
  parameter int unsigned STORE_WAIT = 1
) (
  input  logic        clk_i,
  input  logic        rst_n_i,
  input  logic [2:0]  x_fun_i,
  input  logic        x_load_i,
  input  logic        x_store_i,
  input  logic [4:0]  x_rd_i,
  input  logic [31:0] x_rd_value_i,
  input  logic        x_rd_write_i,
  input  logic [31:0] x_dm_addr_i,
  input  logic [31:0] dm_data_l_i,
  input  logic        dm_load_done_i,
  input  logic        dm_store_done_i,
  output logic [4:0]  rf_rd_o,
  output logic [31:0] rf_rd_value_o,
  output logic        rf_rd_write_o,
  output logic        w_stall_req_o,
  output logic        w_misaligned_o
);

`ifdef URV_WB_MISALIGN_CHECK_EN
  localparam bit MisalignCheck = 1'b1;
`else
  localparam bit MisalignCheck = 1'b0;
`endif

  localparam bit StoreWait = (STORE_WAIT != 0);

  wb_state_e   state_q, state_d;
  logic [4:0]  hold_rd_q, hold_rd_d;
  logic [2:0]  hold_fun_q, hold_fun_d;
  logic [1:0]  hold_addr_q, hold_addr_d;
  logic [4:0]  rf_rd_q, rf_rd_d;
  logic [31:0] rf_value_q, rf_value_d;
  logic        rf_write_q, rf_write_d;
  logic        mis_q, mis_d;

  logic [2:0]  al_fun;
  logic [1:0]  al_addr;
  logic [4:0]  ld_rd;
  logic [31:0] al_value;
  logic        al_valid;
  logic        al_mis;
  logic        ld_done;
  logic        stall;

  // Only the byte offset of the address matters to writeback
  logic unused_addr;
  assign unused_addr = ^x_dm_addr_i[31:2];

  // Aligner operands: live execute bundle in IDLE, held copy while waiting
  always_comb begin
    al_fun  = x_fun_i;
    al_addr = x_dm_addr_i[1:0];
    ld_rd   = x_rd_i;
    if (state_q == WB_WAIT_LOAD) begin
      al_fun  = hold_fun_q;
      al_addr = hold_addr_q;
      ld_rd   = hold_rd_q;
    end
  end

  rv_load_align u_load_align (
    .data_i       (dm_data_l_i),
    .fun_i        (al_fun),
    .addr_i       (al_addr),
    .value_o      (al_value),
    .valid_o      (al_valid),
    .misaligned_o (al_mis)
  );

  // FSM next state, hold capture, RF write generation and stall request
  always_comb begin
    state_d     = state_q;
    hold_rd_d   = hold_rd_q;
    hold_fun_d  = hold_fun_q;
    hold_addr_d = hold_addr_q;
    rf_rd_d     = rf_rd_q;
    rf_value_d  = rf_value_q;
    rf_write_d  = 1'b0;
    mis_d       = 1'b0;
    ld_done     = 1'b0;
    stall       = 1'b0;

    unique case (state_q)
      WB_IDLE: begin
        // Load beats store beats plain write when several qualifiers are set
        if (x_load_i) begin
          if (dm_load_done_i) begin
            ld_done = 1'b1;
          end else begin
            hold_rd_d   = x_rd_i;
            hold_fun_d  = x_fun_i;
            hold_addr_d = x_dm_addr_i[1:0];
            state_d     = WB_WAIT_LOAD;
            stall       = 1'b1;
          end
        end else if (x_store_i) begin
          if (StoreWait && !dm_store_done_i) begin
            state_d = WB_WAIT_STORE;
            stall   = 1'b1;
          end
        end else if (x_rd_write_i && (x_rd_i != 5'd0)) begin
          rf_write_d = 1'b1;
          rf_rd_d    = x_rd_i;
          rf_value_d = x_rd_value_i;
        end
      end
      WB_WAIT_LOAD: begin
        if (dm_load_done_i) begin
          ld_done = 1'b1;
          state_d = WB_IDLE;
        end else begin
          stall = 1'b1;
        end
      end
      WB_WAIT_STORE: begin
        if (dm_store_done_i) begin
          state_d = WB_IDLE;
        end else begin
          stall = 1'b1;
        end
      end
      default: begin
        state_d = WB_IDLE;
      end
    endcase

    if (ld_done) begin
      mis_d = MisalignCheck && al_mis;
      if (al_valid && !mis_d && (ld_rd != 5'd0)) begin
        rf_write_d = 1'b1;
        rf_rd_d    = ld_rd;
        rf_value_d = al_value;
      end
    end
  end

  // State, hold and RF output registers
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      state_q     <= WB_IDLE;
      hold_rd_q   <= '0;
      hold_fun_q  <= '0;
      hold_addr_q <= '0;
      rf_rd_q     <= '0;
      rf_value_q  <= '0;
      rf_write_q  <= 1'b0;
      mis_q       <= 1'b0;
    end else begin
      state_q     <= state_d;
      hold_rd_q   <= hold_rd_d;
      hold_fun_q  <= hold_fun_d;
      hold_addr_q <= hold_addr_d;
      rf_rd_q     <= rf_rd_d;
      rf_value_q  <= rf_value_d;
      rf_write_q  <= rf_write_d;
      mis_q       <= mis_d;
    end
  end

  assign rf_rd_o        = rf_rd_q;
  assign rf_rd_value_o  = rf_value_q;
  assign rf_rd_write_o  = rf_write_q;
  assign w_stall_req_o  = stall;
  assign w_misaligned_o = mis_q;

endmodule

// File: tb/tb_rv_writeback.sv
// Self-checking bench for rv_writeback: directed scenarios followed by a
// randomized sequence checked against a behavioural load/write model.
module tb_rv_writeback;

`ifdef URV_WB_MISALIGN_CHECK_EN
  localparam bit MisEn = 1'b1;
`else
  localparam bit MisEn = 1'b0;
`endif

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst_n = 1'b1;
  logic [2:0]  x_fun;
  logic        x_load, x_store, x_store0, x_we;
  logic [4:0]  x_rd;
  logic [31:0] x_val, x_addr, dm_data;
  logic        ld_done, st_done;

  logic [4:0]  rf_rd;
  logic [31:0] rf_val;
  logic        rf_we, stall, mis;
  logic        stall0, we0;
  logic [4:0]  unused_rd0;
  logic [31:0] unused_val0;
  logic        unused_mis0;

  rv_writeback #(.STORE_WAIT(1)) dut (
    .clk_i (clk), .rst_n_i (rst_n), .x_fun_i (x_fun), .x_load_i (x_load),
    .x_store_i (x_store), .x_rd_i (x_rd), .x_rd_value_i (x_val), .x_rd_write_i (x_we),
    .x_dm_addr_i (x_addr), .dm_data_l_i (dm_data), .dm_load_done_i (ld_done),
    .dm_store_done_i (st_done), .rf_rd_o (rf_rd), .rf_rd_value_o (rf_val),
    .rf_rd_write_o (rf_we), .w_stall_req_o (stall), .w_misaligned_o (mis)
  );

  // Second instance only sees stores, to observe the STORE_WAIT=0 behaviour
  rv_writeback #(.STORE_WAIT(0)) dut_nw (
    .clk_i (clk), .rst_n_i (rst_n), .x_fun_i (x_fun), .x_load_i (1'b0),
    .x_store_i (x_store0), .x_rd_i (x_rd), .x_rd_value_i (x_val), .x_rd_write_i (1'b0),
    .x_dm_addr_i (x_addr), .dm_data_l_i (dm_data), .dm_load_done_i (ld_done),
    .dm_store_done_i (st_done), .rf_rd_o (unused_rd0), .rf_rd_value_o (unused_val0),
    .rf_rd_write_o (we0), .w_stall_req_o (stall0), .w_misaligned_o (unused_mis0)
  );

  int n_checks = 0;
  int n_pass   = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed %h expected %h", tag, obs, exp);
  endtask

  task automatic idle_in();
    x_fun = 3'd0; x_load = 1'b0; x_store = 1'b0; x_store0 = 1'b0; x_we = 1'b0;
    x_rd = 5'd0; x_val = 32'd0; x_addr = 32'd0; dm_data = 32'd0;
    ld_done = 1'b0; st_done = 1'b0;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Reference load semantics computed arithmetically from funct3 and byte offset
  function automatic void ref_load(input logic [2:0] fun, input logic [1:0] a,
                                   input logic [31:0] d, output bit ok, output bit m,
                                   output logic [31:0] v);
    logic [31:0] b, h;
    int unsigned off;
    off = a;
    b = (d >> (8 * off)) & 32'hFF;
    h = (d >> (16 * (off / 2))) & 32'hFFFF;
    ok = 1'b1; m = 1'b0; v = 32'd0;
    case (fun)
      3'd0: v = (b >= 32'd128) ? b - 32'd256 : b;
      3'd4: v = b;
      3'd1: begin v = (h >= 32'd32768) ? h - 32'd65536 : h; m = (off % 2) != 0; end
      3'd5: begin v = h; m = (off % 2) != 0; end
      3'd2: begin v = d; m = off != 0; end
      default: ok = 1'b0;
    endcase
    m = m & MisEn;
  endfunction

  initial begin
    bit ok, m, exp_we;
    logic [31:0] ev, data;
    logic [4:0]  rd;
    logic [2:0]  fun;
    logic [1:0]  a;
    int unsigned op, k;

    idle_in();
    #2 rst_n = 1'b0;
    #1;
    check("reset_we", rf_we, 1'b0);
    check("reset_rd", rf_rd, 5'd0);
    check("reset_val", rf_val, 32'd0);
    check("reset_mis", mis, 1'b0);
    check("reset_stall", stall, 1'b0);
    repeat (2) @(posedge clk);
    @(negedge clk) rst_n = 1'b1;
    tick();

    // ALU write
    idle_in(); x_we = 1'b1; x_rd = 5'd5; x_val = 32'hDEADBEEF;
    #1 check("alu_stall", stall, 1'b0);
    tick();
    check("alu_we", rf_we, 1'b1);
    check("alu_rd", rf_rd, 5'd5);
    check("alu_val", rf_val, 32'hDEADBEEF);
    x_rd = 5'd0;
    tick();
    check("alu_rd0_we", rf_we, 1'b0);

    // Zero-wait LB and LBU at byte 3
    idle_in(); x_load = 1'b1; x_fun = 3'b000; x_addr = 32'h0000_1003; x_rd = 5'd7;
    dm_data = 32'h80FF_1234; ld_done = 1'b1;
    #1 check("lb_stall", stall, 1'b0);
    tick();
    check("lb_we", rf_we, 1'b1);
    check("lb_val", rf_val, 32'hFFFF_FF80);
    x_fun = 3'b100;
    #1 check("lbu_stall", stall, 1'b0);
    tick();
    check("lbu_we", rf_we, 1'b1);
    check("lbu_val", rf_val, 32'h0000_0080);

    // Waited LH with upstream noise while waiting
    idle_in(); x_load = 1'b1; x_fun = 3'b001; x_addr = 32'h0000_2002; x_rd = 5'd9;
    #1 check("lh_stall0", stall, 1'b1);
    for (int j = 1; j <= 3; j++) begin
      tick();
      check("lh_wait_we", rf_we, 1'b0);
      x_load = j[0]; x_we = 1'b1; x_rd = 5'(j + 20); x_fun = 3'b010; x_addr = 32'h3;
      x_val = 32'h1111_1111;
      ld_done = (j == 3);
      dm_data = (j == 3) ? 32'h9ABC_0000 : 32'h5555_5555;
      #1 check("lh_stall", stall, (j != 3));
    end
    tick();
    check("lh_we", rf_we, 1'b1);
    check("lh_rd", rf_rd, 5'd9);
    check("lh_val", rf_val, 32'hFFFF_9ABC);

    // Store waited two cycles
    idle_in(); x_store = 1'b1; x_store0 = 1'b1;
    #1 check("st_stall0", stall, 1'b1);
    check("st_nowait_stall", stall0, 1'b0);
    for (int j = 1; j <= 2; j++) begin
      tick();
      check("st_wait_we", rf_we, 1'b0);
      idle_in(); st_done = (j == 2);
      #1 check("st_stall", stall, (j != 2));
    end
    tick();
    check("st_we", rf_we, 1'b0);

    // Misaligned LW at offset 1, one wait cycle
    idle_in(); x_load = 1'b1; x_fun = 3'b010; x_addr = 32'h0000_1001; x_rd = 5'd11;
    tick();
    idle_in(); ld_done = 1'b1; dm_data = 32'h1234_5678;
    tick();
    check("mis_flag", mis, MisEn);
    check("mis_we", rf_we, !MisEn);
    if (!MisEn) check("mis_val", rf_val, 32'h1234_5678);
    idle_in();
    tick();
    check("mis_pulse_end", mis, 1'b0);

    // Reset in the middle of a pending load
    idle_in(); x_we = 1'b1; x_rd = 5'd3; x_val = 32'h55;
    tick();
    idle_in(); x_load = 1'b1; x_fun = 3'b010; x_rd = 5'd12;
    tick();
    idle_in();
    #2 rst_n = 1'b0;
    #1;
    check("rst_mid_rd", rf_rd, 5'd0);
    check("rst_mid_val", rf_val, 32'd0);
    check("rst_mid_we", rf_we, 1'b0);
    check("rst_mid_stall", stall, 1'b0);
    @(negedge clk) rst_n = 1'b1;
    tick();
    ld_done = 1'b1; dm_data = 32'hCAFE_F00D;
    #1 check("rst_done_stall", stall, 1'b0);
    tick();
    check("rst_done_we", rf_we, 1'b0);

    // Randomized sequence against the reference model
    for (int i = 0; i < 300; i++) begin
      op = $urandom_range(0, 3);
      k  = $urandom_range(0, 3);
      rd = 5'($urandom_range(0, 31));
      idle_in();
      case (op)
        0: begin
          x_we = 1'b1; x_rd = rd; x_val = $urandom; x_fun = 3'($urandom); x_addr = $urandom;
          ev = x_val;
          #1 check("r_alu_stall", stall, 1'b0);
          tick();
          check("r_alu_we", rf_we, (rd != 5'd0));
          if (rd != 5'd0) begin
            check("r_alu_rd", rf_rd, rd);
            check("r_alu_val", rf_val, ev);
          end
        end
        1: begin
          fun = 3'($urandom); x_addr = $urandom; a = x_addr[1:0]; data = $urandom;
          ref_load(fun, a, data, ok, m, ev);
          exp_we = ok && !m && (rd != 5'd0);
          x_load = 1'b1; x_fun = fun; x_rd = rd; x_we = 1'($urandom);
          ld_done = (k == 0); dm_data = (k == 0) ? data : $urandom;
          #1 check("r_ld_stall0", stall, (k != 0));
          for (int j = 1; j <= int'(k); j++) begin
            tick();
            check("r_ld_wait_we", rf_we, 1'b0);
            x_load = 1'($urandom); x_we = 1'b1; x_rd = 5'($urandom); x_fun = 3'($urandom);
            x_addr = $urandom; ld_done = (j == int'(k));
            dm_data = (j == int'(k)) ? data : $urandom;
            #1 check("r_ld_stall", stall, (j != int'(k)));
          end
          tick();
          check("r_ld_we", rf_we, exp_we);
          check("r_ld_mis", mis, m);
          if (exp_we) begin
            check("r_ld_rd", rf_rd, rd);
            check("r_ld_val", rf_val, ev);
          end
        end
        2: begin
          x_store = 1'b1; x_store0 = 1'b1; st_done = (k == 0);
          #1 check("r_st_stall0", stall, (k != 0));
          check("r_st_nw_stall", stall0, 1'b0);
          for (int j = 1; j <= int'(k); j++) begin
            tick();
            check("r_st_wait_we", rf_we, 1'b0);
            idle_in(); st_done = (j == int'(k));
            #1 check("r_st_stall", stall, (j != int'(k)));
            check("r_st_nw_stall", stall0, 1'b0);
          end
          tick();
          check("r_st_we", rf_we, 1'b0);
          check("r_st_nw_we", we0, 1'b0);
        end
        default: begin
          ld_done = 1'($urandom); st_done = 1'($urandom); dm_data = $urandom;
          #1 check("r_stray_stall", stall, 1'b0);
          tick();
          check("r_stray_we", rf_we, 1'b0);
        end
      endcase
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
